// File: rtl/lab7_sos_poll_pkg.sv
// Shared types and helpers for the signal poll master.
package lab7_sos_poll_pkg;

  typedef enum logic [1:0] {
    ST_WAIT,
    ST_REQ,
    ST_LAT,
    ST_UPDATE
  } poll_state_t;

  // Bits needed to count 0..value-1, never less than 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned w;
    for (w = 1; w < 32; w++) begin
      if ((32'd1 << w) >= value) break;
    end
    return w;
  endfunction

endpackage

// File: rtl/lab7_sos_edge_capture.sv
// Sticky per-bit rise/fall capture with per-bit clear and registered irq.
module lab7_sos_edge_capture #(
  parameter int unsigned DATA_W = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_update,
  input  logic [DATA_W-1:0] i_new,
  input  logic [DATA_W-1:0] i_old,
  input  logic [DATA_W-1:0] i_clear,
  output logic [DATA_W-1:0] o_rise_cap,
  output logic [DATA_W-1:0] o_fall_cap,
  output logic              o_irq
);

  logic [DATA_W-1:0] r_rise;
  logic [DATA_W-1:0] r_fall;
  logic              r_irq;
  logic [DATA_W-1:0] w_rise_set;
  logic [DATA_W-1:0] w_fall_set;

  always_comb begin
    w_rise_set = '0;
    w_fall_set = '0;
    if (i_update) begin
      w_rise_set = i_new & ~i_old;
      w_fall_set = ~i_new & i_old;
    end
  end

  // Clear is applied first so a same-cycle new edge still lands.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_rise <= '0;
      r_fall <= '0;
      r_irq  <= 1'b0;
    end else begin
      r_rise <= (r_rise & ~i_clear) | w_rise_set;
      r_fall <= (r_fall & ~i_clear) | w_fall_set;
      r_irq  <= |(r_rise | r_fall);
    end
  end

  assign o_rise_cap = r_rise;
  assign o_fall_cap = r_fall;
  assign o_irq      = r_irq;

endmodule

// File: rtl/lab7_sos_sig_poll_master.sv
// Avalon-MM master that periodically reads a signal PIO and tracks bit edges.
module lab7_sos_sig_poll_master
  import lab7_sos_poll_pkg::*;
#(
  parameter int unsigned ADDR_W       = 2,
  parameter int unsigned DATA_W       = 2,
  parameter int unsigned POLL_PERIOD  = 1000,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned TIMEOUT      = 255,
  parameter int unsigned TARGET_ADDR  = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] sig_value,
  output logic              sig_valid,
  output logic              change_pulse,
  output logic [DATA_W-1:0] rise_cap,
  output logic [DATA_W-1:0] fall_cap,
  input  logic [DATA_W-1:0] cap_clear,
  output logic              irq,
  output logic              timeout_err
);

  localparam int unsigned CNT_W = clog2(POLL_PERIOD);
  localparam int unsigned LAT_W = clog2(READ_LATENCY);
  localparam int unsigned STL_W = clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(POLL_PERIOD - 1);
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);
  localparam logic [STL_W-1:0] STL_LAST = STL_W'(TIMEOUT - 1);

  poll_state_t       r_state;
  poll_state_t       w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [LAT_W-1:0]  r_lat;
  logic [STL_W-1:0]  r_stall;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] r_sig_value;
  logic              r_sig_valid;
  logic              r_change;
  logic              r_terr;

  logic              w_read;
  logic              w_abort;
  logic              w_sample;
  logic              w_update;
  logic              w_unused_rdata;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_WAIT;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_WAIT:   if (enable && (r_cnt == CNT_LAST)) w_next = ST_REQ;
      ST_REQ: begin
        if (!avm_waitrequest)         w_next = ST_LAT;
        else if (r_stall == STL_LAST) w_next = ST_WAIT;
      end
      ST_LAT:    if (r_lat == LAT_LAST) w_next = ST_UPDATE;
      ST_UPDATE: w_next = ST_WAIT;
      default:   w_next = ST_WAIT;
    endcase
  end

  always_comb begin
    w_read   = (r_state == ST_REQ);
    w_abort  = w_read && avm_waitrequest && (r_stall == STL_LAST);
    w_sample = (r_state == ST_LAT) && (r_lat == LAT_LAST);
    w_update = (r_state == ST_UPDATE);
  end

  // Period counter only advances in WAIT, so it sits at 0 through a transaction.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if ((r_state == ST_WAIT) && enable) begin
      r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || (r_state != ST_REQ)) r_stall <= '0;
    else if (avm_waitrequest)         r_stall <= r_stall + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset || (r_state != ST_LAT)) r_lat <= '0;
    else                              r_lat <= r_lat + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_data      <= '0;
      r_sig_value <= '0;
      r_sig_valid <= 1'b0;
      r_change    <= 1'b0;
      r_terr      <= 1'b0;
    end else begin
      if (w_sample) r_data <= avm_readdata[DATA_W-1:0];
      r_change <= w_update && r_sig_valid && (r_data != r_sig_value);
      if (w_update) begin
        r_sig_value <= r_data;
        r_sig_valid <= 1'b1;
      end
      if (w_abort) r_terr <= 1'b1;
    end
  end

  lab7_sos_edge_capture #(
    .DATA_W(DATA_W)
  ) u_edge_capture (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_update   (w_update && r_sig_valid),
    .i_new      (r_data),
    .i_old      (r_sig_value),
    .i_clear    (cap_clear),
    .o_rise_cap (rise_cap),
    .o_fall_cap (fall_cap),
    .o_irq      (irq)
  );

  // Readdata bits above DATA_W are don't-care.
  assign w_unused_rdata = ^avm_readdata;

  assign avm_read     = w_read;
  assign avm_address  = w_read ? ADDR_W'(TARGET_ADDR) : '0;
  assign sig_value    = r_sig_value;
  assign sig_valid    = r_sig_valid;
  assign change_pulse = r_change;
  assign timeout_err  = r_terr;

endmodule

// File: tb/tb_lab7_sos_sig_poll_master.sv
// Scoreboard bench: slave model pushes expected samples on acceptance, monitor pops them on due edge.
module tb_lab7_sos_sig_poll_master;

  localparam int unsigned AW   = 2;
  localparam int unsigned DW   = 2;
  localparam int unsigned PP   = 8;
  localparam int unsigned RL   = 2;
  localparam int unsigned TO   = 8;
  localparam int unsigned TGT  = 2;
  localparam int unsigned SPAN = PP + RL + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          enable = 1'b0;
  logic [AW-1:0] avm_address;
  logic          avm_read;
  logic          avm_waitrequest = 1'b0;
  logic [31:0]   avm_readdata = '0;
  logic [DW-1:0] sig_value;
  logic          sig_valid;
  logic          change_pulse;
  logic [DW-1:0] rise_cap;
  logic [DW-1:0] fall_cap;
  logic [DW-1:0] cap_clear = '0;
  logic          irq;
  logic          timeout_err;

  lab7_sos_sig_poll_master #(
    .ADDR_W      (AW),
    .DATA_W      (DW),
    .POLL_PERIOD (PP),
    .READ_LATENCY(RL),
    .TIMEOUT     (TO),
    .TARGET_ADDR (TGT)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .enable         (enable),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .sig_value      (sig_value),
    .sig_valid      (sig_valid),
    .change_pulse   (change_pulse),
    .rise_cap       (rise_cap),
    .fall_cap       (fall_cap),
    .cap_clear      (cap_clear),
    .irq            (irq),
    .timeout_err    (timeout_err)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } sb_t;

  sb_t           sb[$];
  int unsigned   edges = 0;
  logic          rst_s = 1'b1;
  logic [DW-1:0] clr_s = '0;
  logic [DW-1:0] slave_val = DW'(1);
  int unsigned   terr_due = 0;

  // Edge bookkeeping: what reset/cap_clear were at each rising edge.
  initial forever begin
    @(posedge clk);
    edges++;
    rst_s = reset;
    clr_s = cap_clear;
  end

  // Slave model: drives readdata at the sample edge only, garbage elsewhere.
  initial begin
    int unsigned   cd;
    int unsigned   stall_n;
    logic [DW-1:0] pend;
    logic          hit;
    logic          was_stall;
    logic          was_done;
    sb_t           ent;
    cd = 0; stall_n = 0; pend = '0; was_stall = 1'b0; was_done = 1'b0;
    forever begin
      @(negedge clk); #1;
      if (rst_s) begin
        stall_n = 0;
      end else begin
        if (was_stall) check_eq("read_hold", {31'd0, avm_read}, 32'd1);
        if (was_done)  check_eq("read_drop", {31'd0, avm_read}, 32'd0);
      end
      was_stall = 1'b0;
      was_done  = 1'b0;
      hit = 1'b0;
      if (cd != 0) begin
        cd--;
        hit = (cd == 0);
      end
      avm_readdata = $urandom();
      avm_readdata[DW-1:0] = hit ? pend : ~pend;
      if (!reset && avm_read) begin
        if (!avm_waitrequest) begin
          pend     = slave_val;
          cd       = RL;
          ent.due  = edges + RL + 2;
          ent.data = slave_val;
          sb.push_back(ent);
          stall_n  = 0;
          was_done = 1'b1;
        end else begin
          stall_n++;
          if (stall_n == TO) begin
            terr_due = edges + 1;
            stall_n  = 0;
            was_done = 1'b1;
          end else begin
            was_stall = 1'b1;
          end
        end
      end else begin
        stall_n = 0;
      end
    end
  end

  // Monitor: behavioural model advanced once per edge, all outputs compared.
  initial begin
    logic [DW-1:0] m_val, m_rise, m_fall, set_r, set_f;
    logic          m_valid, m_chg, m_irq, m_terr;
    sb_t           e;
    m_val = '0; m_rise = '0; m_fall = '0;
    m_valid = 1'b0; m_chg = 1'b0; m_irq = 1'b0; m_terr = 1'b0;
    forever begin
      @(negedge clk); #2;
      if (rst_s) begin
        m_val = '0; m_rise = '0; m_fall = '0;
        m_valid = 1'b0; m_chg = 1'b0; m_irq = 1'b0; m_terr = 1'b0;
        sb.delete();
        check_eq("rst_read", {31'd0, avm_read}, 32'd0);
      end else begin
        set_r = '0;
        set_f = '0;
        m_chg = 1'b0;
        m_irq = |(m_rise | m_fall);
        if (sb.size() != 0 && sb[0].due == edges) begin
          e = sb.pop_front();
          if (m_valid) begin
            set_r = e.data & ~m_val;
            set_f = ~e.data & m_val;
            m_chg = (e.data != m_val);
          end
          m_val   = e.data;
          m_valid = 1'b1;
        end
        m_rise = (m_rise & ~clr_s) | set_r;
        m_fall = (m_fall & ~clr_s) | set_f;
        if (terr_due == edges) m_terr = 1'b1;
      end
      check_eq("sig_value",    32'(sig_value),  32'(m_val));
      check_eq("sig_valid",    {31'd0, sig_valid},    {31'd0, m_valid});
      check_eq("change_pulse", {31'd0, change_pulse}, {31'd0, m_chg});
      check_eq("rise_cap",     32'(rise_cap),   32'(m_rise));
      check_eq("fall_cap",     32'(fall_cap),   32'(m_fall));
      check_eq("irq",          {31'd0, irq},          {31'd0, m_irq});
      check_eq("timeout_err",  {31'd0, timeout_err},  {31'd0, m_terr});
      check_eq("address",      32'(avm_address), avm_read ? TGT : 32'd0);
    end
  end

  task automatic wait_read_rise(output int unsigned at);
    int unsigned n;
    n = 0;
    while (avm_read && n < 100) begin @(negedge clk); n++; end
    while (!avm_read && n < 100) begin @(negedge clk); n++; end
    check_eq("read_seen", {31'd0, avm_read}, 32'd1);
    at = edges;
  endtask

  task automatic clear_caps(input logic [DW-1:0] mask);
    cap_clear = mask;
    @(negedge clk);
    cap_clear = '0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int unsigned t0, t1, t2, n;
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned t0, t1, t2, n;
    repeat (3) @(negedge clk);
    reset  = 1'b0;
    enable = 1'b1;
    t0 = edges;

    // Basic poll: first read PP edges after enable, then one every SPAN.
    wait_read_rise(t1);
    check_eq("first_poll", t1 - t0, PP);
    wait_read_rise(t2);
    check_eq("poll_period", t2 - t1, SPAN);
    slave_val = DW'(2);
    repeat (8) @(negedge clk);
    clear_caps('1);

    // Waitrequest stall for 5 cycles.
    slave_val = DW'(1);
    avm_waitrequest = 1'b1;
    wait_read_rise(t1);
    repeat (5) @(negedge clk);
    check_eq("stall_read", {31'd0, avm_read}, 32'd1);
    avm_waitrequest = 1'b0;
    repeat (6) @(negedge clk);

    // Timeout: waitrequest stuck high, then a normal poll.
    slave_val = DW'(0);
    avm_waitrequest = 1'b1;
    n = 0;
    while (!timeout_err && n < 100) begin @(negedge clk); n++; end
    check_eq("terr_seen", {31'd0, timeout_err}, 32'd1);
    avm_waitrequest = 1'b0;
    wait_read_rise(t1);
    repeat (6) @(negedge clk);
    clear_caps('1);

    // Clear and set on bit 0 in the same cycle.
    slave_val = DW'(1);
    n = 0;
    while (!(sb.size() != 0 && sb[0].due == edges + 1) && n < 100) begin
      @(negedge clk);
      n++;
    end
    cap_clear = DW'(1);
    @(negedge clk);
    cap_clear = '0;
    check_eq("collide_rise0", {31'd0, rise_cap[0]}, 32'd1);
    repeat (3) @(negedge clk);

    // Reset while the read is in its latency phase.
    slave_val = DW'(2);
    wait_read_rise(t1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_eq("rst_sig_valid", {31'd0, sig_valid}, 32'd0);
    repeat (6) @(negedge clk);
    check_eq("late_data_ignored", {31'd0, sig_valid}, 32'd0);
    wait_read_rise(t1);
    repeat (6) @(negedge clk);
    check_eq("fresh_valid", {31'd0, sig_valid}, 32'd1);
    check_eq("fresh_value", 32'(sig_value), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lab7_sos_sig_poll_master.md
Name: lab7_sos_sig_poll_master

Overview:
- Avalon-MM master that periodically reads a read-only input-port slave, such as the switch/signal PIO, and publishes a debounced-by-sampling view of the signal bits.
- Issues one read per poll period, honours waitrequest, and captures readdata after a fixed read latency.
- Detects per-bit rising and falling edges, holds them in sticky capture registers, and raises a level interrupt.
- Sits between the PIO slave and fabric logic that needs switch state without a CPU.

Parameters:
- ADDR_W, 2, width of avm_address.
- DATA_W, 2, number of low readdata bits treated as signal bits (1..32).
- POLL_PERIOD, 1000, clk cycles between read issues (>=4).
- READ_LATENCY, 1, cycles from accepted read to valid readdata (1..4).
- TIMEOUT, 255, max cycles read may stall on waitrequest before abort.
- TARGET_ADDR, 0, word address read each poll.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  polling enabled when high.
- avm_address  output  ADDR_W  read address, equal to TARGET_ADDR while avm_read is high, else 0.
- avm_read  output  1  read request.
- avm_waitrequest  input  1  slave stall.
- avm_readdata  input  32  slave read data.
- sig_value  output  DATA_W  last sampled signal bits.
- sig_valid  output  1  high once the first sample has landed.
- change_pulse  output  1  one-cycle pulse when a new sample differs from sig_value.
- rise_cap  output  DATA_W  sticky 0->1 edges per bit.
- fall_cap  output  DATA_W  sticky 1->0 edges per bit.
- cap_clear  input  DATA_W  per-bit clear of rise_cap and fall_cap.
- irq  output  1  OR of rise_cap and fall_cap.
- timeout_err  output  1  sticky, set on read abort; cleared only by reset.

Behaviour:
- Reset values: all outputs 0; state WAIT; period counter 0.
- Reset takes effect on the next clk edge. Reset mid-transaction drops avm_read immediately; no data is captured.
- WAIT:
  - Counter increments while enable=1 and holds while enable=0.
  - At POLL_PERIOD-1: counter clears, go to REQ.
  - The first poll after reset occurs POLL_PERIOD cycles after enable rises.
- REQ:
  - avm_read=1, avm_address=TARGET_ADDR.
  - avm_read and avm_address stay stable while avm_waitrequest=1.
  - Acceptance happens on the edge where avm_read=1 and avm_waitrequest=0; go to LAT with the latency counter at 0.
  - Stall counter increments each waitrequest cycle. On reaching TIMEOUT: drop read, set timeout_err, return to WAIT.
  - enable falling during REQ does not abort the read.
- LAT:
  - avm_read=0.
  - readdata is sampled on the READ_LATENCY-th edge after acceptance; then go to UPDATE.
- UPDATE (one cycle):
  - new = avm_readdata[DATA_W-1:0] as captured.
  - If sig_valid=1:
    - rise_cap |= new & ~sig_value.
    - fall_cap |= ~new & sig_value.
    - change_pulse=1 if new != sig_value.
  - If sig_valid=0: no edges or pulse for the first sample.
  - Then sig_value <= new, sig_valid <= 1, return to WAIT.
- Registered outputs: change_pulse, sig_value and the capture registers update on the same edge leaving UPDATE.
- Clear vs. capture: cap_clear applies every cycle. When a clear and a new edge hit the same bit in the same cycle, the set wins.
- irq is registered: irq = |(rise_cap|fall_cap) as of the next cycle.
- Latency: from entering REQ with no stall, sig_value updates READ_LATENCY+2 edges later.
- Bits above DATA_W in readdata are ignored.

Decomposition:
- Package lab7_sos_poll_pkg holds the state enum (WAIT, REQ, LAT, UPDATE) and a clog2 helper for the counter widths.
- One sub-module, lab7_sos_edge_capture: per-bit rise/fall sticky registers with the clear and set-priority logic and the irq reduction.
- The FSM, counters and Avalon interface stay in the top level.

Test Plan:
- Basic poll:
  - Stimulus: POLL_PERIOD=8, READ_LATENCY=1, no waitrequest, slave returns 2'b01.
  - Response: avm_read is high for exactly 1 cycle every 8+3 cycles; sig_value=01, sig_valid=1; no change_pulse or irq on the first sample.
- Edge capture:
  - Stimulus: slave returns 01 then 10 on the next poll.
  - Response: change_pulse for 1 cycle; rise_cap=10, fall_cap=01; irq=1 the next cycle.
  - Follow-up: cap_clear=11 gives rise_cap=fall_cap=00 and irq=0.
- Waitrequest stall:
  - Stimulus: waitrequest held for 5 cycles.
  - Response: avm_read and avm_address stay stable for 6 cycles; data is captured READ_LATENCY cycles after acceptance; timeout_err=0.
- Timeout:
  - Stimulus: TIMEOUT=4, waitrequest held high.
  - Response: after 4 stall cycles avm_read drops and timeout_err=1 (sticky); the next poll proceeds normally.
- Clear/set collision:
  - Stimulus: cap_clear[0]=1 asserted in the UPDATE cycle that detects a bit-0 rise.
  - Response: rise_cap[0]=1.
- Reset mid-read:
  - Stimulus: reset asserted during LAT with READ_LATENCY=3.
  - Response: next cycle all outputs are 0 and avm_read=0; late readdata is ignored; sig_valid stays 0 until a fresh poll.
